// File: rtl/instr_pkg.sv
// Shared instruction-word definitions used by both the encoder and the decoder.
package instr_pkg;

    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 10;

    localparam int OPC_LSB  = 6;
    localparam int RA_LSB   = 2;
    localparam int RA_W     = 4;
    localparam int RB_RR_W  = 2;
    localparam int IMM6_W   = 6;
    localparam int IMM5_LSB = 1;
    localparam int IMM5_W   = 5;
    localparam int FLAG_POS = 0;

    typedef enum logic [1:0] {
        FMT_RR    = 2'd0,
        FMT_IMM6  = 2'd1,
        FMT_IMM5B = 2'd2,
        FMT_RSVD  = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational fields-to-word packer with legality flag.
// ENC_FIELD_CHECK_EN enables rejection of reserved formats and oversized operands.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [1:0]          i_fmt,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [RA_W-1:0]     i_ra,
    input  logic [5:0]          i_rb,
    input  logic                i_bit,
    output logic [INSTR_W-1:0]  o_word,
    output logic                o_legal
);

    // Build the word; the reserved format falls through to the IMM6 layout.
    always_comb begin
        o_word = {INSTR_W{1'b0}};
        o_word[OPC_LSB +: OPCODE_W] = i_opcode;
        case (fmt_e'(i_fmt))
            FMT_RR: begin
                o_word[RA_LSB +: RA_W]  = i_ra;
                o_word[0 +: RB_RR_W]    = i_rb[RB_RR_W-1:0];
            end
            FMT_IMM5B: begin
                o_word[IMM5_LSB +: IMM5_W] = i_rb[IMM5_W-1:0];
                o_word[FLAG_POS]           = i_bit;
            end
            default: begin
                o_word[0 +: IMM6_W] = i_rb[IMM6_W-1:0];
            end
        endcase
    end

    // Legality: only meaningful when field checking is compiled in.
    always_comb begin
        o_legal = 1'b1;
`ifdef ENC_FIELD_CHECK_EN
        case (fmt_e'(i_fmt))
            FMT_RR:    o_legal = (i_rb[5:2] == 4'd0);
            FMT_IMM5B: o_legal = (i_rb[5] == 1'b0);
            FMT_IMM6:  o_legal = 1'b1;
            default:   o_legal = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into instruction memory at consecutive addresses.
// Optional field checking: define ENC_FIELD_CHECK_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                finish,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_fmt,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [3:0]          in_ra,
    input  logic [5:0]          in_rb,
    input  logic                in_bit,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                full,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    enc_state_e            r_state;
    enc_state_e            w_state_nxt;
    logic [ADDR_W:0]       r_count;
    logic [ADDR_W:0]       w_count_nxt;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [INSTR_W-1:0]    r_mem_wdata;
    logic                  r_done;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_we_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic [INSTR_W-1:0]    w_word;

    instr_field_pack u_pack (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_ra     (in_ra),
        .i_rb     (in_rb),
        .i_bit    (in_bit),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign in_ready = (r_state == ST_LOAD) && !start && !clear;
    assign w_accept = in_valid && in_ready;

    // Next-state and write decision; priority is clear > start > finish > accept.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt = ST_LOAD;
            w_count_nxt = {(ADDR_W+1){1'b0}};
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept && w_legal) begin
                        w_we_nxt    = 1'b1;
                        w_count_nxt = r_count + ONE;
                    end else begin
                        w_err_nxt = w_accept;
                    end
                    // An early finish wins over the FULL transition of the last word.
                    if (finish) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_we_nxt && (r_count == LAST_IDX)) begin
                        w_state_nxt = ST_FULL;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (finish) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_IDLE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counter and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= {(ADDR_W+1){1'b0}};
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {INSTR_W{1'b0}};
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_we_nxt ? r_count[ADDR_W-1:0] : {ADDR_W{1'b0}};
            r_mem_wdata <= w_we_nxt ? w_word : {INSTR_W{1'b0}};
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign busy      = (r_state == ST_LOAD);
    assign full      = (r_state == ST_FULL);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, corner sequences and random traffic.
module tb_instr_encoder;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, finish, clear, in_valid, in_bit;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [3:0]        in_opcode, in_ra;
    logic [5:0]        in_rb;
    logic              mem_we, busy, full, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [9:0]        mem_wdata;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_bit(in_bit),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .full(full), .done(done), .err(err)
    );

    typedef struct {
        int fmt; int op; int ra; int rb; int b; int word;
    } vec_t;

    vec_t tbl [8];
    int total = 0;
    int bad   = 0;

    // Reference model: number of words in the current load plus two mode flags.
    int m_n;
    bit m_loading, m_full;
    bit e_we, e_done, e_err;
    int e_addr, e_word;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_encode(input int fmt, input int op, input int ra,
                                        input int rb, input int b);
        if (fmt == 0) return op * 64 + ra * 4 + (rb % 4);
        if (fmt == 2) return op * 64 + (rb % 32) * 2 + b;
        return op * 64 + rb;
    endfunction

    function automatic bit model_legal(input int fmt, input int rb);
`ifdef ENC_FIELD_CHECK_EN
        if (fmt == 3) return 1'b0;
        if (fmt == 0 && rb >= 4) return 1'b0;
        if (fmt == 2 && rb >= 32) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic drive(input bit s, input bit f, input bit c, input bit v,
                         input int fmt, input int op, input int ra, input int rb, input int b);
        start = s; finish = f; clear = c; in_valid = v;
        in_fmt = 2'(fmt); in_opcode = 4'(op); in_ra = 4'(ra); in_rb = 6'(rb); in_bit = 1'(b);
    endtask

    // One clock: inputs already driven at the falling edge; predict, clock, compare.
    task automatic cycle();
        bit rdy, acc, lg;
        #1;
        rdy = m_loading && !start && !clear;
        check("in_ready", int'(in_ready), int'(rdy));
        acc    = in_valid && rdy;
        lg     = model_legal(int'(in_fmt), int'(in_rb));
        e_we   = acc && lg;
        e_err  = acc && !lg;
        e_addr = m_n;
        e_word = model_encode(int'(in_fmt), int'(in_opcode), int'(in_ra), int'(in_rb), int'(in_bit));
        e_done = 1'b0;
        if (clear) begin
            m_loading = 1'b0; m_full = 1'b0;
        end else if (start) begin
            m_loading = 1'b1; m_full = 1'b0; m_n = 0;
        end else if (m_loading) begin
            if (e_we) m_n++;
            if (finish) begin
                m_loading = 1'b0; e_done = 1'b1;
            end else if (e_we && m_n == DEPTH) begin
                m_loading = 1'b0; m_full = 1'b1; e_done = 1'b1;
            end
        end else if (m_full && finish) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check("mem_we", int'(mem_we), int'(e_we));
        if (e_we) begin
            check("mem_addr", int'(mem_addr), e_addr);
            check("mem_wdata", int'(mem_wdata), e_word);
        end
        check("done", int'(done), int'(e_done));
        check("err", int'(err), int'(e_err));
        check("count", int'(count), m_n);
        check("busy", int'(busy), int'(m_loading));
        check("full", int'(full), int'(m_full));
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, int'(mem_we), 0);
        check({tag, "_addr"}, int'(mem_addr), 0);
        check({tag, "_wdata"}, int'(mem_wdata), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        tbl[0] = '{fmt: 0, op: 'h3, ra: 'h5, rb: 'h02, b: 0, word: 'h0D6};
        tbl[1] = '{fmt: 1, op: 'hA, ra: 'hF, rb: 'h3F, b: 0, word: 'h2BF};
        tbl[2] = '{fmt: 2, op: 'h1, ra: 'h0, rb: 'h0C, b: 1, word: 'h059};
        tbl[3] = '{fmt: 0, op: 'hF, ra: 'hF, rb: 'h03, b: 1, word: 'h3FF};
        tbl[4] = '{fmt: 1, op: 'h0, ra: 'h7, rb: 'h00, b: 1, word: 'h000};
        tbl[5] = '{fmt: 2, op: 'hC, ra: 'h2, rb: 'h1F, b: 0, word: 'h33E};
        tbl[6] = '{fmt: 0, op: 'h8, ra: 'h0, rb: 'h01, b: 0, word: 'h201};
        tbl[7] = '{fmt: 2, op: 'h7, ra: 'h9, rb: 'h00, b: 1, word: 'h1C1};

        m_n = 0; m_loading = 1'b0; m_full = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst_rel");

        // Encoding table in two loads; the first load also overruns the depth.
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
                cycle();
            end
            drive(0, 0, 0, 1, tbl[i].fmt, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].b);
            cycle();
            check("tbl_word", int'(mem_wdata), tbl[i].word);
            check("tbl_addr", int'(mem_addr), i % 4);
            if (i == 3) begin
                check("last_done", int'(done), 1);
                drive(0, 0, 0, 1, tbl[4].fmt, tbl[4].op, tbl[4].ra, tbl[4].rb, tbl[4].b);
                cycle();
                check("overrun_we", int'(mem_we), 0);
                check("overrun_full", int'(full), 1);
                check("overrun_count", int'(count), DEPTH);
            end
        end

        // Early finish coinciding with the third accept.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 2), 0, 1, tbl[i].fmt, tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].b);
            cycle();
        end
        check("fin_addr", int'(mem_addr), 2);
        check("fin_done", int'(done), 1);
        check("fin_busy", int'(busy), 0);
        drive(0, 0, 0, 1, 1, 5, 0, 5, 0);
        cycle();
        check("idle_no_we", int'(mem_we), 0);

        // Oversized RR operand and reserved format.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0, 2, 3, 'h04, 0);
        cycle();
`ifndef ENC_FIELD_CHECK_EN
        check("trunc_rr", int'(mem_wdata), 'h08C);
`endif
        drive(0, 0, 0, 1, 3, 5, 0, 'h2A, 0);
        cycle();
`ifndef ENC_FIELD_CHECK_EN
        check("rsvd_imm6", int'(mem_wdata), 'h16A);
`endif
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(15) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(31) == 0), ($urandom_range(3) != 0),
                  int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(63)), int'($urandom_range(1)));
            cycle();
        end

        // Reset asserted right after an accept drops the write.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, tbl[0].fmt, tbl[0].op, tbl[0].ra, tbl[0].rb, tbl[0].b);
        cycle();
        @(posedge clk);
        #1;
        check("pre_rst_we", int'(mem_we), 1);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all_zero("mid_rst");
        m_n = 0; m_loading = 1'b0; m_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, tbl[1].fmt, tbl[1].op, tbl[1].ra, tbl[1].rb, tbl[1].b);
        cycle();
        check("post_rst_no_we", int'(mem_we), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, tbl[1].fmt, tbl[1].op, tbl[1].ra, tbl[1].rb, tbl[1].b);
        cycle();
        check("post_rst_word", int'(mem_wdata), tbl[1].word);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs opcode/operand fields into 10-bit instruction words and streams them into instruction memory at consecutive addresses. It is the write-side counterpart of the instruction decoder: every word it produces decodes back to the same fields. It sits between the host/program-load path and the instruction memory write port and is used to load programs before and between runs.

## Interface
Parameters:
- ADDR_W, 6, instruction memory address width
- DEPTH, 64, number of writable words; DEPTH ≤ 2**ADDR_W

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin a load at address 0
- finish  in  1  pulse: end the load early
- clear  in  1  pulse: abort and return to idle
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts the bundle this cycle
- in_fmt  in  2  0=RR, 1=IMM6, 2=IMM5B, 3=reserved
- in_opcode  in  4  opcode, placed in word[9:6]
- in_ra  in  4  register A (RR format)
- in_rb  in  6  register B / immediate
- in_bit  in  1  flag bit (IMM5B format)
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  10  encoded instruction
- count  out  ADDR_W+1  words written in the current load
- busy  out  1  state is LOAD
- full  out  1  state is FULL
- done  out  1  one-cycle pulse when a load ends
- err  out  1  one-cycle pulse on a rejected bundle

## Operation
- Encoding, in word layout [9:6 | 5:0]:
  - RR: {opcode, ra[3:0], rb[1:0]}
  - IMM6: {opcode, rb[5:0]}
  - IMM5B: {opcode, rb[4:0], bit}
- FSM states IDLE, LOAD, FULL.
  - IDLE --start--> LOAD: write pointer and count are set to 0.
  - LOAD --finish--> IDLE, with done.
  - LOAD: an accept at pointer DEPTH-1 moves to FULL, with done.
  - FULL --start--> LOAD, restarting at 0.
  - FULL --finish--> IDLE, without done.
  - clear in any state --> IDLE; pointer and count are kept.
- in_ready = (state==LOAD) && !start && !clear && !finish_pending. The last term is always 0 in this build, so finish and accept may coincide.
- Accept = in_valid && in_ready. Each accept writes one word at the pointer, then increments the pointer and count.
- Input priority within a cycle: clear > start > finish > accept.
  - start while in LOAD restarts at address 0; no accept happens that cycle.
  - finish together with an accept: the word is written, then the FSM goes to IDLE with done.
- A rejected bundle (see Configuration) produces no write and leaves pointer and count unchanged.

## Timing
- Reset: state IDLE, pointer 0, count 0. All outputs are 0.
- Output latency: one cycle. An accept at edge N asserts mem_we/mem_addr/mem_wdata for exactly the cycle after edge N.
- Throughput: one word per cycle while in LOAD.
- done asserts in the same cycle as the final mem_we, or in the cycle after finish is accepted.
- err asserts in the cycle after the rejected accept.
- Reset mid-load: the in-flight write is dropped (mem_we 0) and the FSM returns to IDLE.
- The pointer never wraps. FULL blocks all input until start or clear.

## Configuration
- ENC_FIELD_CHECK_EN defined:
  - These bundles are rejected with err:
    - fmt 3
    - RR with rb[5:2]≠0
    - IMM5B with rb[5]≠0
- ENC_FIELD_CHECK_EN undefined:
  - err is tied to 0.
  - fmt 3 encodes as IMM6.
  - Excess operand bits are silently truncated.

## Structure
- Shared package instr_pkg holds:
  - OPCODE_W = 4
  - INSTR_W = 10
  - format enum (FMT_RR, FMT_IMM6, FMT_IMM5B, FMT_RSVD)
  - field bit positions, also used by the decoder
- Sub-module instr_field_pack: a purely combinational fields-to-word packer plus legality flag. The FSM, pointer and output registers live in instr_encoder.

## Test plan
- Reset, then start. Send RR op=4'h3 ra=4'h5 rb=6'h2. Expect mem_we one cycle later with addr 0 and wdata 10'b0011_0101_10; count becomes 1.
- Back-to-back sequence IMM6 op=4'hA rb=6'h3F, then IMM5B op=4'h1 rb=6'h0C bit=1. Expect writes on consecutive cycles: addr 0 = 10'h2BF, addr 1 = 10'h059.
- With DEPTH=4, stream 5 bundles. Expect:
  - exactly 4 writes at addresses 0–3
  - done together with the addr 3 write
  - full=1 and in_ready=0 afterwards
  - count=4
- finish asserted with a valid bundle at addr 2. Expect the addr 2 write, done the same cycle, then IDLE.
- With ENC_FIELD_CHECK_EN defined, send RR with rb=6'h04, then fmt 3. Expect err pulses, no mem_we, and count unchanged. With the macro undefined, expect both bundles written with truncated fields.
- Deassert rst_n in the cycle after an accept. Expect no mem_we, all outputs 0, and start required before any further writes.
